// File: rtl/serial_logic_32.sv
// Serial 32-bit bitwise logic unit: AND/OR/XOR/NOR computed 2 bits per clock over 16 slices.
// Define SERIAL_LOGIC_ZERO_FLAG_EN to add the registered zero output.
module serial_logic_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_sh_q, a_sh_d;
    logic [31:0] b_sh_q, b_sh_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  slice;
    logic        last_slice;

    // The single 2-bit logic slice shared by all 16 steps.
    always_comb begin
        case (op_q)
            OP_AND:  slice = a_sh_q[1:0] & b_sh_q[1:0];
            OP_OR:   slice = a_sh_q[1:0] | b_sh_q[1:0];
            OP_XOR:  slice = a_sh_q[1:0] ^ b_sh_q[1:0];
            default: slice = ~(a_sh_q[1:0] | b_sh_q[1:0]);
        endcase
    end

    assign last_slice = (state_q == RUN) && (cnt_q == 4'd15);

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Slices enter at the top so slice k lands in result[2k+1:2k] after 16 steps.
                result_d = {slice, result_q[31:2]};
                a_sh_d   = {2'b00, a_sh_q[31:2]};
                b_sh_d   = {2'b00, b_sh_q[31:2]};
                cnt_d    = cnt_q + 4'd1;
                if (last_slice) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_q     <= 2'b00;
            a_sh_q   <= 32'd0;
            b_sh_q   <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic zero_q;

    // Captured from the fully assembled result as DONE is entered; start alone never disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (last_slice) begin
            zero_q <= (result_d == 32'd0);
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_logic_32.sv
// Self-checking bench for serial_logic_32: scoreboard of expected results, timing of busy/done,
// start ignored while running, reset abort and reset/start priority.
module tb_serial_logic_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    serial_logic_32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards the first RUN cycle is being observed.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(o, x, y));
        step();
        start = 1'b0;
    endtask

    // Entered while observing the first busy cycle; checks 16 busy cycles, the done cycle, and the IDLE cycle after.
    task automatic check_run_and_done(input string name);
        logic [31:0] exp;
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) step();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, expected busy=1 done=0", name, n, busy, done);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s done cycle 17: busy=%b done=%b, expected busy=0 done=1", name, busy, done);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty at done, result=%h", name, result);
            exp = 32'hxxxx_xxxx;
        end else begin
            exp = exp_q.pop_front();
            if (result !== exp) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", name, result, exp);
            end
        end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== (exp == 32'd0)) begin
            errors++;
            $display("FAIL %s zero at done: got %b expected %b", name, zero, (exp == 32'd0));
        end
`endif
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s after done: busy=%b done=%b result=%h, expected 0 0 %h", name, busy, done, result, exp);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        step();
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset values: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
        end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b0) begin
            errors++;
            $display("FAIL reset zero: got %b expected 0", zero);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_or();
        issue(2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
        check_run_and_done("or");
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (result !== 32'hF0F0_0F0F || done !== 1'b0) begin
                errors++;
                $display("FAIL or hold %0d: result=%h done=%b, expected f0f00f0f 0", i, result, done);
            end
        end
    endtask

    task automatic test_all_ops();
        logic [1:0]  ops[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [31:0] xs[4]  = '{32'hFFFF_0000, 32'hAAAA_AAAA, 32'h0000_0000, 32'h8000_0001};
        logic [31:0] ys[4]  = '{32'h00FF_FF00, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i]);
            check_run_and_done($sformatf("op%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        // start held high across a whole operation while operands change mid-RUN
        op    = 2'b10;
        a     = 32'h1234_5678;
        b     = 32'h0F0F_F0F0;
        start = 1'b1;
        exp_q.push_back(model(2'b10, 32'h1234_5678, 32'h0F0F_F0F0));
        step();
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) step();
            if (n == 4) begin
                op = 2'b00;
                a  = 32'hFFFF_FFFF;
                b  = 32'hC3C3_3C3C;
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL held run cycle %0d: busy=%b done=%b, expected busy=1 done=0", n, busy, done);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || exp_q.size() == 0 || result !== exp_q[0]) begin
            errors++;
            $display("FAIL held first done: done=%b busy=%b result=%h", done, busy, result);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(model(2'b00, 32'hFFFF_FFFF, 32'hC3C3_3C3C));
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held idle cycle 18: busy=%b done=%b, expected 0 0", busy, done);
        end
        step();
        start = 1'b0;
        check_run_and_done("held second");
    endtask

    task automatic test_reset_mid_run();
        logic no_done = 1'b1;
        issue(2'b11, 32'h5A5A_5A5A, 32'h0F0F_0000);
        for (int n = 2; n <= 8; n++) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort pre-reset busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL abort reset: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
        end
        void'(exp_q.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        checks++;
        if (no_done !== 1'b1) begin
            errors++;
            $display("FAIL abort: done or busy rose after reset, got flag %b expected 1", no_done);
        end
        issue(2'b01, 32'h0000_00FF, 32'hFF00_0000);
        check_run_and_done("or after abort");
    endtask

    task automatic test_reset_with_start();
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst+start: busy=%b done=%b, expected 0 0", busy, done);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
                errors++;
                $display("FAIL rst+start idle %0d: busy=%b done=%b result=%h, expected 0 0 0", i, busy, done, result);
            end
        end
    endtask

    task automatic test_zero_flag();
        issue(2'b00, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
        check_run_and_done("zero and");
        issue(2'b01, 32'h0000_0001, 32'h0000_0000);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL zero held across start: got %b expected 1", zero);
        end
`endif
        check_run_and_done("zero or");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_or();
        test_all_ops();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_with_start();
        test_zero_flag();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: %0d entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
